mux_nto1_pipe: RTL and testbench
================================

Name: mux_nto1_pipe

Overview:
- Parametrised N-channel, WIDTH-bit selector with one registered output stage and valid/ready handshakes on every input channel and on the output.
- Two selection modes: explicit select, or round-robin arbitration among valid channels.
- Sits between datapath producers (forwarding, writeback sources, multi-unit results) and a single consumer stage.
- Replaces the combinational 4-to-1 muxes wherever the source must be held until the consumer accepts it.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_CH, 4, number of input channels, 2..16.
- SEL_W, 2, select width; must equal ceil(log2(NUM_CH)).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  NUM_CH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
- valid_i  input  NUM_CH  per-channel valid.
- ready_o  output  NUM_CH  per-channel accept; combinational.
- mode_i  input  1  0 = explicit select, 1 = round-robin.
- select_i  input  SEL_W  channel index used in explicit mode.
- data_o  output  WIDTH  registered output data.
- valid_o  output  1  output holds valid data.
- ready_i  input  1  consumer accepts data_o this cycle.
- sel_o  output  SEL_W  index of the channel currently held in data_o.

Behaviour:
- Reset (rst_i=1 at clock edge): valid_o=0, data_o=0, sel_o=0, rr_ptr=NUM_CH-1. ready_o is all 0 while rst_i=1.
- Free slot: space = !valid_o || ready_i.
- Grant, explicit mode: grant = select_i. If select_i >= NUM_CH, nothing is granted.
- Grant, round-robin mode: grant = first k with valid_i[k]=1, searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_CH. Nothing is granted if all valid_i are 0.
- Accept: ready_o[k] = space && granted && (k == grant). Only one bit of ready_o may be high per cycle.
- Transfer in: valid_i[grant] && ready_o[grant]. Next edge: data_o = channel grant data, sel_o = grant, valid_o = 1.
  - In round-robin mode only, rr_ptr = grant.
- Transfer out: valid_o && ready_i. If no transfer in occurs in the same cycle, valid_o drops to 0 next edge; data_o and sel_o keep their last values.
- Simultaneous transfer out and transfer in: the output register reloads with no bubble. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from accepted input to valid_o.
- Stall (valid_o && !ready_i): data_o, sel_o and valid_o are held stable, all ready_o are 0, rr_ptr is held.
- Explicit mode never changes rr_ptr. A mode switch takes effect on the same cycle's grant, with rr_ptr retained.
- select_i and mode_i may change every cycle. Only the values present in a transfer-in cycle matter.
- Reset mid-transfer: any held word is dropped, and the state is exactly as after reset.

Optional Feature:
- Macro: MUX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [15:0].
  - Counts cycles with valid_o && !ready_i and saturates at 16'hFFFF (no wrap).
  - Cleared to 0 by rst_i.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Explicit mode, NUM_CH=4, WIDTH=32, select_i=2, valid_i=4'b0100, data ch2=32'hDEADBEEF, ready_i=1 -> ready_o=4'b0100 this cycle; next cycle data_o=32'hDEADBEEF, sel_o=2, valid_o=1.
- Round-robin, after reset, valid_i=4'b1111 held, ready_i=1 -> sel_o sequence 0,1,2,3,0 on consecutive cycles with valid_o=1 throughout.
- Round-robin, valid_i=4'b1010, ready_i=1 -> sel_o alternates 1,3,1,3; channels 0 and 2 are never granted.
- Backpressure: load ch0=32'h11, then hold ready_i=0 for 3 cycles with ch1 valid -> data_o stays 32'h11, ready_o=0 for 3 cycles. When ready_i returns to 1, data_o becomes ch1 data on the next edge with no bubble.
- Explicit select_i=3 with NUM_CH=3 and all valid_i=1 -> ready_o=0 and valid_o stays 0.
- Assert rst_i for 1 cycle while valid_o=1 -> valid_o=0, data_o=0, sel_o=0 next cycle. With MUX_STALL_CNT_EN, stall_cnt_o=0; after 70000 stall cycles stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-channel valid/ready selector with one registered output stage; explicit or round-robin grant.
// Optional stall counter output enabled by defining MUX_STALL_CNT_EN.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]       valid_i,
  output logic [NUM_CH-1:0]       ready_o,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        select_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        sel_o
`ifdef MUX_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic [SEL_W-1:0] rr_ptr;

  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] idx;
  logic             granted;
  logic             space;
  logic             take;

  // Round-robin search starts one past the last winner so every channel gets a turn.
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    idx     = '0;
    if (!mode_i) begin
      if (int'(select_i) < NUM_CH) begin
        granted = 1'b1;
        grant   = select_i;
      end
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
        if (!granted && valid_i[idx]) begin
          granted = 1'b1;
          grant   = idx;
        end
      end
    end
  end

  assign space   = !valid_q || ready_i;
  assign ready_o = (space && granted && !rst_i) ? (NUM_CH'(1) << grant) : '0;
  assign take    = space && granted && !rst_i && valid_i[grant];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      rr_ptr  <= SEL_W'(NUM_CH - 1);
    end else if (take) begin
      data_q  <= data_i[int'(grant)*WIDTH +: WIDTH];
      sel_q   <= grant;
      valid_q <= 1'b1;
      if (mode_i) rr_ptr <= grant;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

`ifdef MUX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !ready_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_mux_nto1_pipe;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] data;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready_o;
  logic           mode;
  logic [1:0]     select;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           rdy;
  logic [1:0]     sel_o;

  logic [3*W-1:0] data3;
  logic [2:0]     valid3;
  logic [2:0]     ready3_o;
  logic           mode3;
  logic [1:0]     select3;
  logic [W-1:0]   data3_o;
  logic           valid3_o;
  logic           rdy3;
  logic [1:0]     sel3_o;

`ifdef MUX_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt3;
  int          m_stall;
`endif

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(W), .NUM_CH(N), .SEL_W(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready_o),
    .mode_i(mode), .select_i(select), .data_o(data_o), .valid_o(valid_o),
    .ready_i(rdy), .sel_o(sel_o)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  mux_nto1_pipe #(.WIDTH(W), .NUM_CH(3), .SEL_W(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(data3), .valid_i(valid3), .ready_o(ready3_o),
    .mode_i(mode3), .select_i(select3), .data_o(data3_o), .valid_o(valid3_o),
    .ready_i(rdy3), .sel_o(sel3_o)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt3)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state of the output register and arbitration pointer.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Explicit: the select value if in range. Round-robin: valid channel nearest after the pointer.
  function automatic void model_grant(output logic ok, output int g);
    int best_d;
    ok = 1'b0;
    g = 0;
    best_d = N;
    if (!mode) begin
      ok = (int'(select) < N);
      g  = int'(select);
    end else begin
      for (int k = 0; k < N; k++) begin
        int d;
        d = (k - m_ptr - 1 + 2*N) % N;
        if (valid[k] && d < best_d) begin
          best_d = d;
          g = k;
          ok = 1'b1;
        end
      end
    end
  endfunction

  task automatic cycle();
    logic         ok;
    int           g;
    logic         space;
    logic [N-1:0] er;
    #1;
    model_grant(ok, g);
    space = !m_valid || rdy;
    er = (!rst && space && ok) ? N'(1 << g) : '0;
    chk("ready_o", 64'(ready_o), 64'(er));
    last_ready = ready_o;
`ifdef MUX_STALL_CNT_EN
    if (rst) m_stall = 0;
    else if (m_valid && !rdy && m_stall < 65535) m_stall++;
`endif
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = N - 1;
    end else if (er != '0 && valid[g]) begin
      m_valid = 1'b1;
      m_data  = data[g*W +: W];
      m_sel   = g;
      if (mode) m_ptr = g;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid_o), 64'(m_valid));
    chk("data_o", 64'(data_o), 64'(m_data));
    chk("sel_o", 64'(sel_o), 64'(m_sel));
`ifdef MUX_STALL_CNT_EN
    chk("stall_cnt_o", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = '0; valid = '0; mode = 1'b0; select = '0; rdy = 1'b0;
    data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    valid3 = 3'b111; mode3 = 1'b0; select3 = 2'd3; rdy3 = 1'b1;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = N - 1; last_ready = '0;
`ifdef MUX_STALL_CNT_EN
    m_stall = 0;
`endif

    // Reset state
    cycle();
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_data", 64'(data_o), 64'd0);
    rst = 1'b0;

    // Explicit select of channel 2
    mode = 1'b0; select = 2'd2; valid = 4'b0100; rdy = 1'b1;
    data[2*W +: W] = 32'hDEADBEEF;
    cycle();
    chk("expl_ready", 64'(last_ready), 64'b0100);
    chk("expl_data", 64'(data_o), 64'hDEADBEEF);
    chk("expl_sel", 64'(sel_o), 64'd2);
    chk("expl_valid", 64'(valid_o), 64'd1);

    // Round-robin with every channel valid after reset
    do_reset();
    mode = 1'b1; valid = 4'b1111; rdy = 1'b1;
    for (int k = 0; k < N; k++) data[k*W +: W] = 32'hA000_0000 + k;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_all_sel", 64'(sel_o), 64'(i % N));
      chk("rr_all_valid", 64'(valid_o), 64'd1);
    end

    // Round-robin skipping idle channels 0 and 2
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_1010_sel", 64'(sel_o), (i % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Backpressure holds the word, then reloads without a bubble
    do_reset();
    mode = 1'b0; select = 2'd0; valid = 4'b0001; rdy = 1'b1;
    data[0 +: W] = 32'h11; data[W +: W] = 32'h22;
    cycle();
    chk("bp_load", 64'(data_o), 64'h11);
    select = 2'd1; valid = 4'b0010; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", 64'(last_ready), 64'd0);
      chk("bp_hold", 64'(data_o), 64'h11);
    end
    rdy = 1'b1;
    cycle();
    chk("bp_release_data", 64'(data_o), 64'h22);
    chk("bp_release_valid", 64'(valid_o), 64'd1);

    // Out-of-range select on a 3-channel instance never grants
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("oor_ready", 64'(ready3_o), 64'd0);
      chk("oor_valid", 64'(valid3_o), 64'd0);
    end

    // Reset while holding a word
    mode = 1'b0; select = 2'd3; valid = 4'b1000; rdy = 1'b0;
    data[3*W +: W] = 32'h5555_AAAA;
    cycle();
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    do_reset();
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_data", 64'(data_o), 64'd0);
    chk("mid_rst_sel", 64'(sel_o), 64'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      mode   = 1'($urandom_range(0, 1));
      select = 2'($urandom_range(0, 3));
      valid  = N'($urandom);
      rdy    = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 60) == 0);
      for (int k = 0; k < N; k++) data[k*W +: W] = $urandom;
      cycle();
    end
    rst = 1'b0;

`ifdef MUX_STALL_CNT_EN
    // Saturation of the stall counter
    do_reset();
    chk("stall_clr", 64'(stall_cnt), 64'd0);
    mode = 1'b0; select = 2'd0; valid = 4'b0001; rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
